// File: rtl/npc_predict_unit.sv
// npc_predict_unit: fetch-stage next-PC generator with a direct-mapped BTB of
// 2-bit saturating counters, EX-driven training and mispredict redirect/flush.
module npc_predict_unit #(
    parameter int               WIDTH       = 32,
    parameter int               BTB_ENTRIES = 16,
    parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    output logic [WIDTH-1:0] pc_o,
    output logic             pred_taken_o,
    output logic [WIDTH-1:0] pred_target_o,
    input  logic             ex_valid_i,
    input  logic             ex_is_jump_i,
    input  logic [WIDTH-1:0] ex_pc_i,
    input  logic             ex_taken_i,
    input  logic [WIDTH-1:0] ex_target_i,
    input  logic             ex_pred_taken_i,
    input  logic [WIDTH-1:0] ex_pred_target_i,
    output logic             flush_o,
    output logic [31:0]      perf_branches_o,
    output logic [31:0]      perf_mispred_o
);
    localparam int IDX = $clog2(BTB_ENTRIES);
    localparam int TW  = WIDTH - IDX - 2;

    logic [WIDTH-1:0] pc_q, pc_d, pc_inc, tgt_d;
    logic             valid_q [BTB_ENTRIES];
    logic [TW-1:0]    tag_q   [BTB_ENTRIES];
    logic [WIDTH-1:0] tgt_q   [BTB_ENTRIES];
    logic [1:0]       ctr_q   [BTB_ENTRIES];
    logic [31:0]      br_q, mis_q;
    logic [IDX-1:0]   f_idx, e_idx;
    logic [TW-1:0]    e_tag;
    logic [1:0]       ctr_d;
    logic             f_hit, e_hit, mispredict, we;

    always_comb begin
        f_idx         = pc_q[IDX+1:2];
        f_hit         = valid_q[f_idx] && tag_q[f_idx] == pc_q[WIDTH-1:IDX+2];
        pc_inc        = pc_q + WIDTH'(4);
        pred_taken_o  = f_hit && ctr_q[f_idx][1];
        pred_target_o = f_hit ? tgt_q[f_idx] : pc_inc;
        mispredict    = ex_valid_i && (ex_taken_i != ex_pred_taken_i ||
                        (ex_taken_i && ex_target_i != ex_pred_target_i));
        // a redirect from EX wins over stall so a mispredict is never lost
        pc_d          = mispredict ? (ex_taken_i ? ex_target_i : ex_pc_i + WIDTH'(4)) :
                        stall_i ? pc_q : pred_taken_o ? tgt_q[f_idx] : pc_inc;
    end

    always_comb begin
        e_idx = ex_pc_i[IDX+1:2];
        e_tag = ex_pc_i[WIDTH-1:IDX+2];
        e_hit = valid_q[e_idx] && tag_q[e_idx] == e_tag;
        we    = ex_valid_i && (e_hit || ex_taken_i);
        ctr_d = ex_is_jump_i ? 2'b11 :
                !e_hit ? 2'b10 :
                ex_taken_i ? (ctr_q[e_idx] == 2'b11 ? 2'b11 : ctr_q[e_idx] + 2'd1) :
                (ctr_q[e_idx] == 2'b00 ? 2'b00 : ctr_q[e_idx] - 2'd1);
        tgt_d = (ex_taken_i || ex_is_jump_i) ? ex_target_i : tgt_q[e_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            br_q  <= '0;
            mis_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
            end
        end else begin
            pc_q  <= pc_d;
            br_q  <= br_q + 32'(ex_valid_i);
            mis_q <= mis_q + 32'(mispredict);
            if (we) begin
                valid_q[e_idx] <= 1'b1;
                tag_q[e_idx]   <= e_tag;
                tgt_q[e_idx]   <= tgt_d;
                ctr_q[e_idx]   <= ctr_d;
            end
        end
    end

    assign pc_o            = pc_q;
    assign flush_o         = mispredict;
    assign perf_branches_o = br_q;
    assign perf_mispred_o  = mis_q;
endmodule

// File: tb/tb_npc_predict_unit.sv
// tb_npc_predict_unit: directed scenarios plus random EX traffic checked
// against an array-based BTB/PC reference model.
module tb_npc_predict_unit;
    logic        clk = 0, rst = 1, stall = 0;
    logic        ex_valid = 0, ex_is_jump = 0, ex_taken = 0, ex_pred_taken = 0;
    logic [31:0] ex_pc = 0, ex_target = 0, ex_pred_target = 0;
    logic [31:0] pc, pred_target, perf_branches, perf_mispred;
    logic        pred_taken, flush;
    int          checks = 0, errors = 0;

    bit          m_valid [16];
    bit   [31:0] m_tag [16], m_tgt [16];
    int          m_ctr [16];
    bit   [31:0] m_pc, m_br, m_mis;

    npc_predict_unit dut (
        .clk(clk), .rst(rst), .stall_i(stall),
        .pc_o(pc), .pred_taken_o(pred_taken), .pred_target_o(pred_target),
        .ex_valid_i(ex_valid), .ex_is_jump_i(ex_is_jump), .ex_pc_i(ex_pc),
        .ex_taken_i(ex_taken), .ex_target_i(ex_target),
        .ex_pred_taken_i(ex_pred_taken), .ex_pred_target_i(ex_pred_target),
        .flush_o(flush), .perf_branches_o(perf_branches), .perf_mispred_o(perf_mispred)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_br = 0; m_mis = 0;
        for (int k = 0; k < 16; k++) begin
            m_valid[k] = 0;
            m_ctr[k] = 1;
        end
    endtask

    // check every output against the model, then advance the model by one edge
    task automatic cycle();
        int i, j;
        bit hit, h, pt, mis;
        bit [31:0] ptgt;
        @(negedge clk);
        i    = int'((m_pc / 4) % 16);
        hit  = m_valid[i] && m_tag[i] == m_pc / 64;
        pt   = hit && m_ctr[i] >= 2;
        ptgt = hit ? m_tgt[i] : m_pc + 4;
        mis  = ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target));
        chk("pc", pc, m_pc);
        chk("pred_taken", pred_taken, pt);
        chk("pred_target", pred_target, ptgt);
        chk("flush", flush, mis);
        chk("perf_branches", perf_branches, m_br);
        chk("perf_mispred", perf_mispred, m_mis);
        if (rst) model_reset();
        else begin
            j = int'((ex_pc / 4) % 16);
            h = m_valid[j] && m_tag[j] == ex_pc / 64;
            if (ex_valid) begin
                m_br++;
                if (h && ex_is_jump) begin
                    m_ctr[j] = 3; m_tgt[j] = ex_target;
                end else if (h && ex_taken) begin
                    m_ctr[j] = (m_ctr[j] + 1 > 3) ? 3 : m_ctr[j] + 1; m_tgt[j] = ex_target;
                end else if (h) begin
                    m_ctr[j] = (m_ctr[j] - 1 < 0) ? 0 : m_ctr[j] - 1;
                end else if (ex_taken) begin
                    m_valid[j] = 1; m_tag[j] = ex_pc / 64; m_tgt[j] = ex_target;
                    m_ctr[j] = ex_is_jump ? 3 : 2;
                end
            end
            if (mis) m_mis++;
            m_pc = mis ? (ex_taken ? ex_target : ex_pc + 4) : stall ? m_pc : pt ? ptgt : m_pc + 4;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        ex_valid = 0; ex_is_jump = 0; ex_taken = 0; ex_pred_taken = 0;
        ex_pc = 0; ex_target = 0; ex_pred_target = 0; stall = 0;
        #1;
    endtask

    task automatic ex(input bit j, input logic [31:0] p, input bit t, input logic [31:0] tg,
                      input bit pt, input logic [31:0] ptg);
        ex_valid = 1; ex_is_jump = j; ex_pc = p; ex_taken = t; ex_target = tg;
        ex_pred_taken = pt; ex_pred_target = ptg;
        #1;
    endtask

    // not-taken resolution predicted taken: lands fetch exactly on a
    task automatic redirect(input logic [31:0] a);
        ex(0, a - 4, 0, 0, 1, 0);
        cycle();
        idle();
    endtask

    initial begin
        logic [31:0] held;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            chk("t1_pc", pc, 32'(k * 4));
            chk("t1_pred_taken", pred_taken, 0);
            cycle();
        end
        ex(0, 32'h10, 1, 32'h0, 0, 32'h0);
        chk("t2_flush", flush, 1);
        cycle();
        idle();
        chk("t2_redirect_pc", pc, 32'h0);
        repeat (4) cycle();
        chk("t2_pc_at_10", pc, 32'h10);
        chk("t2_pred_taken", pred_taken, 1);
        chk("t2_pred_target", pred_target, 32'h0);
        cycle();
        chk("t2_follow_pc", pc, 32'h0);
        ex(0, 32'h20, 1, 32'h80, 0, 32'h0);
        chk("t3_alloc_flush", flush, 1);
        cycle();
        repeat (2) begin
            ex(0, 32'h20, 1, 32'h80, 1, 32'h80);
            chk("t3_taken_noflush", flush, 0);
            cycle();
        end
        ex(0, 32'h20, 0, 32'h0, 1, 32'h80);
        chk("t3_nt1_flush", flush, 1);
        cycle();
        redirect(32'h20);
        chk("t3_still_taken", pred_taken, 1);
        chk("t3_target", pred_target, 32'h80);
        ex(0, 32'h20, 0, 32'h0, 1, 32'h80);
        chk("t3_nt2_flush", flush, 1);
        cycle();
        redirect(32'h20);
        chk("t3_now_not_taken", pred_taken, 0);
        stall = 1; #1;
        held = pc;
        cycle();
        chk("t4_hold", pc, held);
        ex(0, 32'h40, 1, 32'h100, 0, 32'h0);
        stall = 1; #1;
        cycle();
        idle();
        chk("t4_redirect_over_stall", pc, 32'h100);
        ex(0, 32'h50, 1, 32'h300, 0, 32'h0);
        cycle();
        redirect(32'h10);
        chk("t5_alias_miss", pred_taken, 0);
        chk("t5_alias_target", pred_target, 32'h14);
        redirect(32'hFFFF_FFFC);
        chk("t6_pc_top", pc, 32'hFFFF_FFFC);
        cycle();
        chk("t6_wrap", pc, 32'h0);
        chk("t6_perf_mispred", perf_mispred, m_mis);
        for (int n = 0; n < 800; n++) begin
            rst            = $urandom_range(0, 99) < 2;
            stall          = $urandom_range(0, 3) == 0;
            ex_valid       = !rst && $urandom_range(0, 9) < 4;
            ex_is_jump     = $urandom_range(0, 3) == 0;
            ex_pc          = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC :
                             ($urandom_range(0, 3) << 30) | ($urandom_range(0, 31) << 2);
            ex_taken       = ex_is_jump ? 1'b1 : 1'($urandom_range(0, 1));
            ex_target      = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom_range(0, 63) << 2;
            ex_pred_taken  = 1'($urandom_range(0, 1));
            ex_pred_target = $urandom_range(0, 1) ? ex_target : $urandom_range(0, 63) << 2;
            #1;
            cycle();
        end
        rst = 0;
        idle();
        cycle();
        chk("final_perf_mispred", perf_mispred, m_mis);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
